bsg_async_credit_counter_multi: RTL and testbench

//  Multi-channel clock-crossing credit counter. Credits are returned as tokens in the w_ domain and spent in the r_ domain.

---
 rtl/bsg_async_credit_pkg.sv | 37 +++
 rtl/bsg_async_credit_chan.sv | 154 +++++++++++++++
 rtl/bsg_async_credit_counter_multi.sv | 97 +++++++++
 tb/tb_bsg_async_credit_counter_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_async_credit_pkg.sv
// +--------------------------------------------------------------------+
// | bsg_async_credit_pkg: width helpers, gray coding, free-count type   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package bsg_async_credit_pkg;

  localparam int c_MAX_W = 32;

  // Max-width container for one channel's free count; callers truncate to RW.
  typedef logic [c_MAX_W-1:0] free_slice_t;

  function automatic int ww_f(input int max_tokens, input int extra_margin);
    return extra_margin + $clog2(max_tokens + 1);
  endfunction

  function automatic int rw_f(input int max_tokens, input int extra_margin, input int lg_dec);
    return ww_f(max_tokens, extra_margin) + lg_dec;
  endfunction

  function automatic free_slice_t bin2gray(input free_slice_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic free_slice_t gray2bin(input free_slice_t g);
    free_slice_t b;
    b[c_MAX_W-1] = g[c_MAX_W-1];
    for (int i = c_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_async_credit_chan.sv
// +--------------------------------------------------------------------+
// | bsg_async_credit_chan: one credit channel (w ptr, sync, r counter)  |
// | Optional check: BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN             |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module bsg_async_credit_chan
  import bsg_async_credit_pkg::*;
#(
  parameter int max_tokens_p                    = 4,
  parameter int lg_credit_to_token_decimation_p = 0,
  parameter int extra_margin_p                  = 0,
  parameter int start_full_p                    = 1,
  parameter int sync_stages_p                   = 2,
  parameter int low_water_p                     = 1,
  parameter int count_negedge_p                 = 0,
  localparam int c_WW = ww_f(max_tokens_p, extra_margin_p),
  localparam int c_RW = rw_f(max_tokens_p, extra_margin_p, lg_credit_to_token_decimation_p)
) (
  input  logic            w_clk_i,
  input  logic            w_reset_i,
  input  logic            r_clk_i,
  input  logic            r_reset_i,
  input  logic            i_w_inc_token,
  input  logic            i_r_dec_credit,
  input  logic            i_r_infinite,
  output logic            o_r_avail_raw,
  output logic [c_RW-1:0] o_r_free,
  output logic            o_r_low
`ifdef BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN
  ,
  output logic            o_r_err_set
`endif
);

  localparam int c_LG_DEC = lg_credit_to_token_decimation_p;
  localparam int c_FULL   = (max_tokens_p * start_full_p) << c_LG_DEC;
  localparam logic [c_RW-1:0] c_CNT_RST  = c_RW'(-c_FULL);
  localparam logic [c_RW-1:0] c_FREE_RST = c_RW'(c_FULL);
  localparam logic            c_LOW_RST  = (int'(c_FREE_RST) < low_water_p);

  logic [c_WW-1:0] r_wptr_bin;
  logic [c_WW-1:0] r_wptr_gray;
  logic [c_WW-1:0] w_bin_inc;
  logic [c_WW-1:0] w_gray_inc;

  assign w_bin_inc  = r_wptr_bin + c_WW'(1);
  assign w_gray_inc = c_WW'(bin2gray(free_slice_t'(w_bin_inc)));

  generate
    if (count_negedge_p != 0) begin : g_wptr_negedge
      always_ff @(negedge w_clk_i or posedge w_reset_i) begin
        if (w_reset_i) begin
          r_wptr_bin  <= '0;
          r_wptr_gray <= '0;
        end else if (i_w_inc_token) begin
          r_wptr_bin  <= w_bin_inc;
          r_wptr_gray <= w_gray_inc;
        end
      end
    end else begin : g_wptr_posedge
      always_ff @(posedge w_clk_i or posedge w_reset_i) begin
        if (w_reset_i) begin
          r_wptr_bin  <= '0;
          r_wptr_gray <= '0;
        end else if (i_w_inc_token) begin
          r_wptr_bin  <= w_bin_inc;
          r_wptr_gray <= w_gray_inc;
        end
      end
    end
  endgenerate

  // Only the gray copy crosses; one bit changes per token.
  logic [c_WW-1:0] r_sync [sync_stages_p];

  always_ff @(posedge r_clk_i) begin
    if (r_reset_i) begin
      for (int i = 0; i < sync_stages_p; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= r_wptr_gray;
      for (int i = 1; i < sync_stages_p; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  logic [c_WW-1:0] w_sync_gray;
  logic [c_WW-1:0] w_sync_bin;
  logic [c_RW-1:0] r_cnt;
  logic [c_WW-1:0] w_cnt_hi;
  logic [c_WW-1:0] w_cnt_hi_gray;
  logic            w_lo_nz;
  logic            w_spend;

  assign w_sync_gray   = r_sync[sync_stages_p-1];
  assign w_sync_bin    = c_WW'(gray2bin(free_slice_t'(w_sync_gray)));
  assign w_cnt_hi      = r_cnt[c_RW-1 -: c_WW];
  assign w_cnt_hi_gray = c_WW'(bin2gray(free_slice_t'(w_cnt_hi)));

  generate
    if (c_LG_DEC > 0) begin : g_lo_bits
      assign w_lo_nz = |r_cnt[c_LG_DEC-1:0];
    end else begin : g_no_lo_bits
      assign w_lo_nz = 1'b0;
    end
  endgenerate

  // A partially spent token still has credits left in it.
  assign o_r_avail_raw = w_lo_nz | (w_cnt_hi_gray != w_sync_gray);
  assign w_spend       = i_r_dec_credit & (o_r_avail_raw | i_r_infinite);

  always_ff @(posedge r_clk_i) begin
    if (r_reset_i) begin
      r_cnt <= c_CNT_RST;
    end else if (w_spend) begin
      r_cnt <= r_cnt + c_RW'(1);
    end
  end

  logic [c_RW-1:0] w_free_next;
  logic            w_low_next;
  logic [c_RW-1:0] r_free;
  logic            r_low;

  assign w_free_next = (c_RW'(w_sync_bin) << c_LG_DEC) - r_cnt;
  assign w_low_next  = (int'(w_free_next) < low_water_p);

  always_ff @(posedge r_clk_i) begin
    if (r_reset_i) begin
      r_free <= c_FREE_RST;
      r_low  <= c_LOW_RST;
    end else begin
      r_free <= w_free_next;
      r_low  <= w_low_next;
    end
  end

  assign o_r_free = r_free;
  assign o_r_low  = r_low;

`ifdef BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN
  localparam int c_ERR_LIM = max_tokens_p << (c_LG_DEC + extra_margin_p);

  assign o_r_err_set = (int'(w_free_next) > c_ERR_LIM)
                     | (i_r_dec_credit & ~o_r_avail_raw & ~i_r_infinite);
`endif

endmodule

`default_nettype wire

// File: rtl/bsg_async_credit_counter_multi.sv
// +--------------------------------------------------------------------+
// | bsg_async_credit_counter_multi: multi-channel async credit counter  |
// | Optional check: BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN             |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module bsg_async_credit_counter_multi
  import bsg_async_credit_pkg::*;
#(
  parameter int channels_p                      = 2,
  parameter int max_tokens_p                    = 4,
  parameter int lg_credit_to_token_decimation_p = 0,
  parameter int extra_margin_p                  = 0,
  parameter int start_full_p                    = 1,
  parameter int sync_stages_p                   = 2,
  parameter int low_water_p                     = 1,
  parameter int count_negedge_p                 = 0,
  localparam int c_RW = rw_f(max_tokens_p, extra_margin_p, lg_credit_to_token_decimation_p)
) (
  input  logic                       w_clk_i,
  input  logic                       w_reset_i,
  input  logic                       r_clk_i,
  input  logic                       r_reset_i,
  input  logic [channels_p-1:0]      w_inc_token_i,
  input  logic [channels_p-1:0]      r_dec_credit_i,
  input  logic                       r_infinite_credits_i,
  output logic [channels_p-1:0]      r_credits_avail_o,
  output logic [channels_p*c_RW-1:0] r_free_credits_o,
  output logic [channels_p-1:0]      r_credits_low_o,
  output logic                       r_error_o
);

  logic [channels_p-1:0] w_avail_raw;
`ifdef BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN
  logic [channels_p-1:0] w_err_set;
`endif

  generate
    for (genvar c = 0; c < channels_p; c++) begin : g_chan
      bsg_async_credit_chan #(
        .max_tokens_p                   (max_tokens_p),
        .lg_credit_to_token_decimation_p(lg_credit_to_token_decimation_p),
        .extra_margin_p                 (extra_margin_p),
        .start_full_p                   (start_full_p),
        .sync_stages_p                  (sync_stages_p),
        .low_water_p                    (low_water_p),
        .count_negedge_p                (count_negedge_p)
      ) u_chan (
        .w_clk_i       (w_clk_i),
        .w_reset_i     (w_reset_i),
        .r_clk_i       (r_clk_i),
        .r_reset_i     (r_reset_i),
        .i_w_inc_token (w_inc_token_i[c]),
        .i_r_dec_credit(r_dec_credit_i[c]),
        .i_r_infinite  (r_infinite_credits_i),
        .o_r_avail_raw (w_avail_raw[c]),
        .o_r_free      (r_free_credits_o[c*c_RW +: c_RW]),
        .o_r_low       (r_credits_low_o[c])
`ifdef BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN
        ,
        .o_r_err_set   (w_err_set[c])
`endif
      );

      assign r_credits_avail_o[c] = w_avail_raw[c] | r_infinite_credits_i;
    end
  endgenerate

`ifdef BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN
  logic r_error;

  // Sticky until the next r-domain reset.
  always_ff @(posedge r_clk_i) begin
    if (r_reset_i) begin
      r_error <= 1'b0;
    end else if (|w_err_set) begin
      r_error <= 1'b1;
    end
  end

  assign r_error_o = r_error;

`ifndef SYNTHESIS
  always @(posedge r_clk_i) begin
    if (!r_reset_i && (|w_err_set)) begin
      $error("bsg_async_credit_counter_multi: credit error, channels %b", w_err_set);
    end
  end
`endif
`else
  assign r_error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_async_credit_counter_multi.sv
// +--------------------------------------------------------------------+
// | tb_bsg_async_credit_counter_multi: directed self-checking bench     |
// | Expected error flag follows BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_bsg_async_credit_counter_multi;

`ifdef BSG_ASYNC_CREDIT_COUNTER_MULTI_CHECK_EN
  localparam int c_CHK = 1;
`else
  localparam int c_CHK = 0;
`endif

  logic       w_clk    = 1'b0;
  logic       r_clk    = 1'b0;
  logic       w_clk_en = 1'b1;
  logic       w_reset  = 1'b0;
  logic       r_reset  = 1'b1;
  logic [1:0] w_inc    = '0;
  logic [1:0] r_dec    = '0;
  logic       inf      = 1'b0;
  logic [1:0] avail;
  logic [5:0] free;
  logic [1:0] low;
  logic       err;

  logic       w_inc2 = 1'b0;
  logic       r_dec2 = 1'b0;
  logic [0:0] avail2;
  logic [3:0] free2;
  logic [0:0] low2;
  logic       err2;

  int checks = 0;
  int errors = 0;

  bsg_async_credit_counter_multi u_dut (
    .w_clk_i             (w_clk),
    .w_reset_i           (w_reset),
    .r_clk_i             (r_clk),
    .r_reset_i           (r_reset),
    .w_inc_token_i       (w_inc),
    .r_dec_credit_i      (r_dec),
    .r_infinite_credits_i(inf),
    .r_credits_avail_o   (avail),
    .r_free_credits_o    (free),
    .r_credits_low_o     (low),
    .r_error_o           (err)
  );

  // One channel, two credits per token, starts empty.
  bsg_async_credit_counter_multi #(
    .channels_p                     (1),
    .lg_credit_to_token_decimation_p(1),
    .start_full_p                   (0)
  ) u_dut_dec (
    .w_clk_i             (w_clk),
    .w_reset_i           (w_reset),
    .r_clk_i             (r_clk),
    .r_reset_i           (r_reset),
    .w_inc_token_i       (w_inc2),
    .r_dec_credit_i      (r_dec2),
    .r_infinite_credits_i(1'b0),
    .r_credits_avail_o   (avail2),
    .r_free_credits_o    (free2),
    .r_credits_low_o     (low2),
    .r_error_o           (err2)
  );

  always #5 r_clk = ~r_clk;

  always begin
    #8;
    if (w_clk_en) w_clk = ~w_clk;
    else          w_clk = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    r_reset = 1'b1;
    repeat (2) @(posedge r_clk);
    w_clk_en = 1'b0;
    #20;
    w_inc = '0; w_inc2 = 1'b0; r_dec = '0; r_dec2 = 1'b0; inf = 1'b0;
    w_reset = 1'b1;
    #10;
    w_reset = 1'b0;
    #4;
    w_clk_en = 1'b1;
    repeat (4) @(posedge r_clk);
    @(negedge r_clk);
    r_reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    #1;
    chk({tag, " avail"}, avail, 3);
    chk({tag, " free0"}, free[2:0], 4);
    chk({tag, " free1"}, free[5:3], 4);
    chk({tag, " low"}, low, 0);
    chk({tag, " error"}, err, 0);
    chk({tag, " dec avail"}, avail2, 0);
    chk({tag, " dec free"}, free2, 0);
    chk({tag, " dec low"}, low2, 1);
  endtask

  typedef struct {
    logic [1:0] dec;
    logic       inf;
    logic [1:0] av;
    int         f0;
    int         f1;
    logic [1:0] lw;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // Each row: inputs driven at r negedge; outputs expected before that cycle's edge.
    tbl[0] = '{2'b01, 1'b0, 2'b11, 4, 4, 2'b00};
    tbl[1] = '{2'b01, 1'b0, 2'b11, 4, 4, 2'b00};
    tbl[2] = '{2'b01, 1'b0, 2'b11, 3, 4, 2'b00};
    tbl[3] = '{2'b01, 1'b0, 2'b11, 2, 4, 2'b00};
    tbl[4] = '{2'b00, 1'b0, 2'b10, 1, 4, 2'b00};
    tbl[5] = '{2'b00, 1'b0, 2'b10, 0, 4, 2'b01};
    tbl[6] = '{2'b00, 1'b1, 2'b11, 0, 4, 2'b01};
    tbl[7] = '{2'b00, 1'b0, 2'b10, 0, 4, 2'b01};

    do_reset();
    chk_reset_state("reset");

    for (int i = 0; i < 8; i++) begin
      @(negedge r_clk);
      r_dec = tbl[i].dec;
      inf   = tbl[i].inf;
      #1;
      chk($sformatf("vec%0d avail", i), avail, tbl[i].av);
      chk($sformatf("vec%0d free0", i), free[2:0], tbl[i].f0);
      chk($sformatf("vec%0d free1", i), free[5:3], tbl[i].f1);
      chk($sformatf("vec%0d low", i), low, tbl[i].lw);
      chk($sformatf("vec%0d error", i), err, 0);
    end
    @(negedge r_clk);
    r_dec = '0;
    inf   = 1'b0;

    // Two tokens on ch0
    @(negedge w_clk); w_inc = 2'b01;
    @(posedge w_clk);
    @(posedge w_clk); #1 w_inc = '0;
    repeat (2) @(posedge r_clk);
    #1 chk("tok avail0", avail[0], 1);
    @(posedge r_clk);
    #1 chk("tok free0", free[2:0], 2);
    chk("tok free1", free[5:3], 4);
    chk("tok low0", low[0], 0);

    // Drain ch0 to empty
    @(negedge r_clk); r_dec = 2'b01;
    @(negedge r_clk);
    @(negedge r_clk); r_dec = '0;
    #1 chk("drain avail0", avail[0], 0);
    @(posedge r_clk);
    #1 chk("drain free0", free[2:0], 0);
    chk("drain low0", low[0], 1);

    // Spend while empty, token arriving the same window: spend dropped
    fork
      begin
        @(negedge r_clk); r_dec = 2'b01;
        @(negedge r_clk); r_dec = '0;
      end
      begin
        @(negedge w_clk); w_inc = 2'b01;
        @(posedge w_clk); #1 w_inc = '0;
      end
    join
    repeat (4) @(posedge r_clk);
    #1 chk("drop free0", free[2:0], 1);
    chk("drop avail0", avail[0], 1);
    chk("drop error", err, c_CHK);

    // Spend with credit while a token arrives: net unchanged
    fork
      begin
        @(negedge r_clk); r_dec = 2'b01;
        @(negedge r_clk); r_dec = '0;
      end
      begin
        @(negedge w_clk); w_inc = 2'b01;
        @(posedge w_clk); #1 w_inc = '0;
      end
    join
    repeat (4) @(posedge r_clk);
    #1 chk("both free0", free[2:0], 1);
    chk("both avail0", avail[0], 1);

    // Decimated instance: one token is two credits
    @(negedge w_clk); w_inc2 = 1'b1;
    @(posedge w_clk); #1 w_inc2 = 1'b0;
    repeat (3) @(posedge r_clk);
    #1 chk("dec tok free", free2, 2);
    chk("dec tok avail", avail2, 1);
    chk("dec tok low", low2, 0);
    @(negedge r_clk); r_dec2 = 1'b1;
    @(negedge r_clk); r_dec2 = 1'b0;
    #1 chk("dec half avail", avail2, 1);
    @(posedge r_clk);
    #1 chk("dec half free", free2, 1);
    @(negedge r_clk); r_dec2 = 1'b1;
    @(negedge r_clk); r_dec2 = 1'b0;
    #1 chk("dec empty avail", avail2, 0);
    @(posedge r_clk);
    #1 chk("dec empty free", free2, 0);
    chk("dec empty low", low2, 1);
    chk("dec error", err2, 0);

    // Fifth token on a full ch1 wraps the free count past the limit
    @(negedge w_clk); w_inc = 2'b10;
    @(posedge w_clk); #1 w_inc = '0;
    repeat (3) @(posedge r_clk);
    #1 chk("excess free1", free[5:3], 5);
    chk("excess avail1", avail[1], 1);
    chk("excess error", err, c_CHK);
    @(posedge r_clk);
    #1 chk("excess sticky", err, c_CHK);

    // Full reset procedure with traffic still applied
    @(negedge r_clk);
    r_dec = 2'b11; w_inc = 2'b11; w_inc2 = 1'b1; r_dec2 = 1'b1;
    do_reset();
    chk_reset_state("rereset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
